// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: round-robin sequencer for the shared 8-bit register bus.
// Accepts register-to-register transfer commands from two requesters and
// drives per-register ENABLE/LOAD controls as a PRIME then MOVE sequence,
// so that only one register ever drives the bus.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous, active-low
//   req_valid  per-requester command valid (bit k = requester k)
//   req_src    per-requester source register index
//   req_dst    per-requester destination register index
//   req_ready  per-requester grant (combinational, IDLE only)
//   reg_op     per-register operation (NOP / ENABLE / LOAD)
//   busy       high during PRIME and MOVE
//   done       one-cycle pulse in the IDLE cycle after MOVE
//   done_req   requester id of the completed (or rejected) command
//   err        one-cycle pulse on a rejected command
//
// Optional feature: define BUS_XFER_ERR_EN to reject commands with
// src == dst or an out-of-range index (accepted, not executed, err pulses).
// Without it err is tied low and every accepted command is sequenced.

package bus_xfer_ctrl_pkg;
  typedef enum logic [1:0] {
    NOP    = 2'd0,
    ENABLE = 2'd1,
    LOAD   = 2'd2
  } reg_op_e;
endpackage

module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned IDW      = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0][IDW-1:0] req_src,
  input  logic [1:0][IDW-1:0] req_dst,
  output logic [1:0]          req_ready,
  output reg_op_e             reg_op [NUM_REGS],
  output logic                busy,
  output logic                done,
  output logic                done_req,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    MOVE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic [IDW-1:0] src_q, src_d;
  logic [IDW-1:0] dst_q, dst_d;
  logic           id_q, id_d;
  reg_op_e        reg_op_d [NUM_REGS];
  logic           busy_d;
  logic           done_d;
  logic           done_req_d;
  logic           gnt_id_c;
  logic           accept_c;

  // Round-robin grant: a lone requester wins, otherwise prio wins.
  always_comb begin : arb
    gnt_id_c  = 1'b0;
    req_ready = '0;
    if (state_q == IDLE) begin
      if (req_valid == 2'b11) begin
        gnt_id_c = prio_q;
      end else begin
        gnt_id_c = req_valid[1];
      end
      req_ready[gnt_id_c] = req_valid[gnt_id_c];
    end
  end

  assign accept_c = |(req_valid & req_ready);

`ifdef BUS_XFER_ERR_EN
  logic cmd_bad_c;
  logic err_d;

  // Reject self-transfers and indices beyond the populated register bank.
  always_comb begin : cmd_chk
    cmd_bad_c = (req_src[gnt_id_c] == req_dst[gnt_id_c])
             || (32'(req_src[gnt_id_c]) >= NUM_REGS)
             || (32'(req_dst[gnt_id_c]) >= NUM_REGS);
  end
`endif

  // Next-state, latch and registered-output decode.
  always_comb begin : next_state
    state_d    = state_q;
    prio_d     = prio_q;
    src_d      = src_q;
    dst_d      = dst_q;
    id_d       = id_q;
    done_d     = 1'b0;
    done_req_d = done_req;
`ifdef BUS_XFER_ERR_EN
    err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          prio_d = ~gnt_id_c;
          id_d   = gnt_id_c;
          src_d  = req_src[gnt_id_c];
          dst_d  = req_dst[gnt_id_c];
`ifdef BUS_XFER_ERR_EN
          if (cmd_bad_c) begin
            err_d      = 1'b1;
            done_req_d = gnt_id_c;
          end else begin
            state_d = PRIME;
          end
`else
          state_d = PRIME;
`endif
        end
      end
      PRIME: state_d = MOVE;
      MOVE: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        done_req_d = id_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    // Source ENABLE in both phases; destination LOAD in MOVE overrides it.
    // Indices with no matching register are silently dropped.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_op_d[i] = NOP;
      if ((state_d == PRIME || state_d == MOVE) && src_d == IDW'(i)) begin
        reg_op_d[i] = ENABLE;
      end
      if (state_d == MOVE && dst_d == IDW'(i)) begin
        reg_op_d[i] = LOAD;
      end
    end
  end

  // State and output registers; reset forces every reg_op to NOP at once.
  always_ff @(posedge clock or negedge reset) begin : regs
    if (!reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      id_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_req <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        reg_op[i] <= NOP;
      end
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      id_q     <= id_d;
      busy     <= busy_d;
      done     <= done_d;
      done_req <= done_req_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        reg_op[i] <= reg_op_d[i];
      end
    end
  end

`ifdef BUS_XFER_ERR_EN
  always_ff @(posedge clock or negedge reset) begin : err_reg
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
